// File: rtl/neopixel_pkg.sv
// Shared NeoPixel timing constants and receiver state encoding.
// The transmitter derives its pulse widths from the same nanosecond figures.
package neopixel_pkg;

    localparam int CLK_HZ  = 32_000_000;
    localparam int COLOR_W = 24;

    localparam int T0H_NS     = 400;
    localparam int T1H_NS     = 800;
    localparam int BIT_NS     = 1250;
    localparam int THRESH_NS  = 600;
    localparam int MAX_HIGH_NS = 2000;
    localparam int RESET_NS   = 50_000;

    function automatic int ns_to_cycles(input int ns);
        return (ns * (CLK_HZ / 1_000_000)) / 1000;
    endfunction

    localparam int THRESH_CYCLES_DEF   = ns_to_cycles(THRESH_NS);
    localparam int MAX_HIGH_CYCLES_DEF = ns_to_cycles(MAX_HIGH_NS);
    localparam int RESET_CYCLES_DEF    = ns_to_cycles(RESET_NS);
    localparam int CNT_W_DEF           = 11;

    typedef enum logic [2:0] {
        WAIT_GAP,
        IDLE,
        HIGH,
        LOW,
        PASS
    } rx_state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous pin with rise/fall strobes
// derived from the synchronized level.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic s_din,
    output logic rise,
    output logic fall
);

    logic meta_reg;
    logic sync_reg;
    logic prev_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
            prev_reg <= 1'b0;
        end else begin
            meta_reg <= din;
            sync_reg <= meta_reg;
            prev_reg <= sync_reg;
        end
    end

    assign s_din = sync_reg;
    assign rise  = sync_reg & ~prev_reg;
    assign fall  = ~sync_reg & prev_reg;

endmodule

// File: rtl/neopixel_rx.sv
// WS2812-style one-wire receiver: decodes the first 24 bits of a frame into
// color and forwards the rest of the frame on dout until the latch gap.
module neopixel_rx
    import neopixel_pkg::*;
#(
    parameter int THRESH_CYCLES   = THRESH_CYCLES_DEF,
    parameter int MAX_HIGH_CYCLES = MAX_HIGH_CYCLES_DEF,
    parameter int RESET_CYCLES    = RESET_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic               CLK,
    input  logic               reset_n,
    input  logic               din,
    output logic [COLOR_W-1:0] color,
    output logic               color_valid,
    output logic               dout,
    output logic               frame_active,
    output logic               error
);

    localparam int BIT_CNT_W = $clog2(COLOR_W + 1);
    localparam logic [CNT_W-1:0]     THRESH_C   = CNT_W'(THRESH_CYCLES);
    localparam logic [CNT_W-1:0]     MAX_HIGH_C = CNT_W'(MAX_HIGH_CYCLES);
    localparam logic [CNT_W-1:0]     GAP_C      = CNT_W'(RESET_CYCLES);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT   = BIT_CNT_W'(COLOR_W - 1);

    logic s_din;
    logic s_rise;
    logic s_fall;

    sync_edge u_sync (
        .clk   (CLK),
        .rst_n (reset_n),
        .din   (din),
        .s_din (s_din),
        .rise  (s_rise),
        .fall  (s_fall)
    );

    rx_state_t            state_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic [CNT_W-1:0]     run_len;
    logic [BIT_CNT_W-1:0] bit_cnt_reg;
    logic [COLOR_W-1:0]   shadow_reg;
    logic                 bit_val;
    logic                 gap_seen;
    logic                 overflow;

    // run_len is the length of the current s_din level including this cycle;
    // on a falling edge cnt_reg therefore still holds the completed high width.
    always_comb begin
        if (s_rise || s_fall) begin
            run_len = CNT_W'(1);
        end else if (&cnt_reg) begin
            run_len = cnt_reg;
        end else begin
            run_len = cnt_reg + CNT_W'(1);
        end
    end

    assign bit_val  = (cnt_reg >= THRESH_C);
    assign gap_seen = !s_din && (run_len >= GAP_C);
    assign overflow = s_din && (run_len > MAX_HIGH_C);

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= WAIT_GAP;
            cnt_reg      <= '0;
            bit_cnt_reg  <= '0;
            shadow_reg   <= '0;
            color        <= '0;
            color_valid  <= 1'b0;
            dout         <= 1'b0;
            frame_active <= 1'b0;
            error        <= 1'b0;
        end else begin
            cnt_reg     <= run_len;
            color_valid <= 1'b0;
            error       <= 1'b0;
            dout        <= 1'b0;
            case (state_reg)
                WAIT_GAP: begin
                    frame_active <= 1'b0;
                    bit_cnt_reg  <= '0;
                    if (gap_seen) begin
                        state_reg <= IDLE;
                    end
                end
                IDLE: begin
                    if (s_rise) begin
                        state_reg    <= HIGH;
                        frame_active <= 1'b1;
                        bit_cnt_reg  <= '0;
                    end
                end
                HIGH: begin
                    if (s_fall) begin
                        shadow_reg  <= {shadow_reg[COLOR_W-2:0], bit_val};
                        bit_cnt_reg <= bit_cnt_reg + BIT_CNT_W'(1);
                        if (bit_cnt_reg == LAST_BIT) begin
                            color       <= {shadow_reg[COLOR_W-2:0], bit_val};
                            color_valid <= 1'b1;
                            state_reg   <= PASS;
                        end else begin
                            state_reg <= LOW;
                        end
                    end else if (overflow) begin
                        error        <= 1'b1;
                        frame_active <= 1'b0;
                        state_reg    <= WAIT_GAP;
                    end
                end
                LOW: begin
                    if (s_rise) begin
                        state_reg <= HIGH;
                    end else if (gap_seen) begin
                        error        <= (bit_cnt_reg != '0);
                        frame_active <= 1'b0;
                        state_reg    <= IDLE;
                    end
                end
                PASS: begin
                    if (gap_seen) begin
                        frame_active <= 1'b0;
                        state_reg    <= IDLE;
                    end else begin
                        dout <= s_din;
                    end
                end
                default: begin
                    state_reg <= WAIT_GAP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neopixel_rx.sv
// Scoreboard bench for neopixel_rx: a frame-level model predicts colour/error
// events and the forwarded dout waveform; a negedge monitor checks them.
module tb_neopixel_rx;

    localparam int THRESH    = 19;
    localparam int MAXH      = 64;
    localparam int GAP       = 1600;
    localparam int GAP_DRIVE = 1700;
    localparam int DOUT_N    = 131072;
    localparam int MAX_BITS  = 64;

    typedef struct {
        bit          is_err;
        logic [23:0] color;
        int          lo;
        int          hi;
    } exp_t;

    logic        CLK = 1'b0;
    logic        reset_n = 1'b0;
    logic        din = 1'b0;
    logic [23:0] color;
    logic        color_valid;
    logic        dout;
    logic        frame_active;
    logic        error;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    exp_t        exp_q[$];
    bit          exp_dout [DOUT_N];
    int          hi_w [MAX_BITS];
    int          lo_w [MAX_BITS];
    bit          fwd [MAX_BITS];
    bit          armed = 1'b0;
    logic [23:0] last_color = '0;
    bit          exp_fa_mid = 1'b0;

    neopixel_rx dut (
        .CLK          (CLK),
        .reset_n      (reset_n),
        .din          (din),
        .color        (color),
        .color_valid  (color_valid),
        .dout         (dout),
        .frame_active (frame_active),
        .error        (error)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: dout every cycle, and each colour/error pulse against the queue.
    always @(negedge CLK) begin
        exp_t e;
        if (cyc < DOUT_N) chk(dout == exp_dout[cyc], "dout", 32'(dout), 32'(exp_dout[cyc]));
        if (color_valid || error) begin
            $display("cycle %0d: %s color=%06h", cyc, error ? "error" : "color_valid", color);
            chk(!(color_valid && error), "valid_with_error", 32'({color_valid, error}), 32'(0));
            chk(exp_q.size() != 0, "event_expected", 32'({color_valid, error}), 32'(0));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk(error == e.is_err, "event_kind_err", 32'(error), 32'(e.is_err));
                if (!e.is_err) chk(color == e.color, "color", 32'(color), 32'(e.color));
                chk(cyc >= e.lo && cyc <= e.hi, "event_time", 32'(cyc), 32'(e.lo));
            end
        end
    end

    task automatic drive(input logic v, input int n, input bit mark);
        din = v;
        if (mark) begin
            for (int k = 0; k < n; k++) begin
                if (cyc + 3 + k < DOUT_N) exp_dout[cyc + 3 + k] = 1'b1;
            end
        end
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic set_word(input logic [23:0] w, input int base, input bit rnd);
        for (int i = 0; i < 24; i++) begin
            if (w[23 - i]) begin
                hi_w[base + i] = rnd ? int'($urandom_range(19, 50)) : 26;
                lo_w[base + i] = rnd ? int'($urandom_range(8, 40)) : 14;
            end else begin
                hi_w[base + i] = rnd ? int'($urandom_range(4, 18)) : 13;
                lo_w[base + i] = rnd ? int'($urandom_range(8, 40)) : 27;
            end
        end
    endtask

    // Frame-level reference: first 24 pulse widths form the word, longer
    // pulses abort, short frames error at the gap, the rest go to dout.
    task automatic model_frame(input int nb, input int reset_at);
        int          t;
        int          tf;
        logic [23:0] w;
        bit          alive;
        exp_t        e;
        t          = cyc;
        tf         = cyc;
        w          = '0;
        alive      = armed;
        exp_fa_mid = armed;
        for (int i = 0; i < nb; i++) begin
            fwd[i] = 1'b0;
            if (i == reset_at) begin
                alive      = 1'b0;
                last_color = '0;
            end
            if (alive && i < 24) begin
                if (hi_w[i] > MAXH) begin
                    e.is_err = 1'b1; e.color = '0; e.lo = t + MAXH + 1; e.hi = t + MAXH + 5;
                    exp_q.push_back(e);
                    alive = 1'b0;
                end else begin
                    w = {w[22:0], (hi_w[i] >= THRESH)};
                    if (i == 23) begin
                        e.is_err = 1'b0; e.color = w; e.lo = t + hi_w[i] + 2; e.hi = t + hi_w[i] + 5;
                        exp_q.push_back(e);
                        last_color = w;
                    end
                end
            end else if (alive) begin
                fwd[i] = 1'b1;
            end
            if (i <= 1 && !alive) exp_fa_mid = 1'b0;
            tf = t + hi_w[i];
            t  = t + hi_w[i] + lo_w[i];
        end
        if (alive && nb > 0 && nb < 24) begin
            e.is_err = 1'b1; e.color = '0; e.lo = tf + GAP; e.hi = tf + GAP + 5;
            exp_q.push_back(e);
        end
        armed = 1'b1;
    endtask

    task automatic send_frame(input int nb, input int reset_at);
        model_frame(nb, reset_at);
        for (int i = 0; i < nb; i++) begin
            if (i == reset_at) begin
                reset_n = 1'b0;
                #1;
                chk(color == '0, "reset_mid_color", 32'(color), 32'(0));
                chk(color_valid == 1'b0, "reset_mid_valid", 32'(color_valid), 32'(0));
                chk(frame_active == 1'b0, "reset_mid_frame_active", 32'(frame_active), 32'(0));
                chk(error == 1'b0, "reset_mid_error", 32'(error), 32'(0));
                repeat (4) begin
                    @(posedge CLK);
                    #1;
                end
                reset_n = 1'b1;
            end
            drive(1'b1, hi_w[i], fwd[i]);
            drive(1'b0, lo_w[i], 1'b0);
            if (i == 1) chk(frame_active == exp_fa_mid, "frame_active_mid", 32'(frame_active), 32'(exp_fa_mid));
        end
        drive(1'b0, GAP_DRIVE, 1'b0);
        chk(frame_active == 1'b0, "frame_active_after_gap", 32'(frame_active), 32'(0));
        chk(color == last_color, "color_held", 32'(color), 32'(last_color));
    endtask

    initial begin
        logic [23:0] rw;
        int          nb;
        reset_n = 1'b0;
        din     = 1'b0;
        repeat (3) begin
            @(posedge CLK);
            #1;
        end
        chk(color == '0, "reset_color", 32'(color), 32'(0));
        chk(color_valid == 1'b0, "reset_valid", 32'(color_valid), 32'(0));
        chk(dout == 1'b0, "reset_dout", 32'(dout), 32'(0));
        chk(frame_active == 1'b0, "reset_frame_active", 32'(frame_active), 32'(0));
        chk(error == 1'b0, "reset_error", 32'(error), 32'(0));
        reset_n = 1'b1;

        drive(1'b0, GAP_DRIVE, 1'b0);
        armed = 1'b1;

        set_word(24'hA5C33C, 0, 1'b0);
        send_frame(24, -1);

        set_word(24'h123456, 0, 1'b0);
        set_word(24'hFEDCBA, 24, 1'b0);
        send_frame(48, -1);

        set_word(24'h000000, 0, 1'b0);
        hi_w[0] = 18;
        hi_w[1] = 19;
        send_frame(24, -1);

        set_word(24'hB7E151, 0, 1'b0);
        send_frame(10, -1);
        set_word(24'h00FF00, 0, 1'b0);
        send_frame(24, -1);

        set_word(24'h3C3C3C, 0, 1'b0);
        set_word(24'hC3C3C3, 24, 1'b0);
        hi_w[5] = 80;
        send_frame(30, -1);
        set_word(24'h0F0F0F, 0, 1'b0);
        send_frame(24, -1);

        set_word(24'h5A5A5A, 0, 1'b0);
        send_frame(24, 12);
        set_word(24'h96C3E1, 0, 1'b0);
        send_frame(24, -1);

        for (int f = 0; f < 6; f++) begin
            rw = 24'($urandom);
            nb = 24 + int'($urandom_range(0, 8));
            set_word(rw, 0, 1'b1);
            set_word(24'($urandom), 24, 1'b1);
            send_frame(nb, -1);
        end

        drive(1'b0, 50, 1'b0);
        chk(exp_q.size() == 0, "events_outstanding", 32'(exp_q.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
